xeng_cmac_acc_readout: RTL
==========================

// Module: xeng_cmac_acc_readout
// PURPOSE
//  Sink for the packed complex MAC-chain output stream (18b word: [17:9]=real, [8:0]=imag, 2's complement).
//  Accumulates per-baseline products over ACC_LEN frames of N_BASELINES slots, then drains the
//  integrated results through a valid/ready output port. Sits between the dsp48e MAC chain and vector/packetiser logic.
// PARAMETERS
//  N_BASELINES  16  slots per frame; slot index = count of accepted din_valid beats mod N_BASELINES
//  ACC_LEN      8   frames per integration (>=1)
//  IN_W         9   bits per input component
//  ACC_W        24  bits per accumulated component (ACC_W >= IN_W)
//  FIFO_DEPTH   16  output FIFO entries (power of 2)
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  rst        in   1          synchronous reset, active-high
//  din        in   2*IN_W     packed complex product {re,im}
//  din_valid  in   1          din qualifier; no backpressure on input side
//  dout       out  2*ACC_W    integrated result {re,im}
//  dout_valid out  1          dout qualifier
//  dout_ready in   1          downstream accept; beat transfers when dout_valid & dout_ready
//  dout_last  out  1          high with the result for slot N_BASELINES-1
//  overflow   out  1          sticky: a result was dropped (FIFO full); cleared only by rst
// BEHAVIOUR
//  - Reset: slot_cnt=0, frame_cnt=0, FIFO empty, dout_valid=0, dout_last=0, dout=0, overflow=0. Accumulator contents don't-care.
//  - Per accepted beat: re/im sign-extended IN_W->ACC_W. frame_cnt==0: acc[slot]<=ext(din) (no add). Otherwise acc[slot]<=acc[slot]+ext(din), wraps mod 2^ACC_W.
//  - frame_cnt==ACC_LEN-1: sum (acc[slot]+ext(din), or ext(din) if ACC_LEN==1) written to FIFO one cycle after the beat; acc not needed afterwards.
//  - slot_cnt wraps N_BASELINES-1 -> 0 and then increments frame_cnt; frame_cnt wraps ACC_LEN-1 -> 0.
//  - Idle cycles (din_valid=0) freeze all counters and accumulators.
//  - Latency: last-frame beat at cycle t -> earliest dout_valid at t+2 (FIFO write t+1, registered head t+2).
//  - Output: dout/dout_last held stable while dout_valid & !dout_ready. dout_last = FIFO entry tag (slot==N_BASELINES-1).
//  - FIFO full at a write: result dropped, overflow<=1, counters continue. Simultaneous read and write when full: read frees a slot, write accepted, no overflow.
//  - rst mid-integration: partial sums abandoned, FIFO flushed, next beat is slot 0, frame 0.
// CONFIGURATION
//  XENG_ACC_SATURATE_EN defined: per-component add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; saturation also sets overflow.
//  Undefined: modular wrap, overflow reflects FIFO drops only.
// STRUCTURE
//  Shared package xeng_pkg: cplx unpack/sign-extend function, IN_W/ACC_W defaults, {re,im} packing order constant.
//  Sub-module xeng_acc_fifo: sync FIFO, registered head, full/empty flags, data + last tag. Top holds counters, acc array (distributed RAM, 1 write port), datapath.
// TESTING
//  1. N_BASELINES=4, ACC_LEN=2, din re=1 im=-1 every cycle, dout_ready=1 -> 4 results re=2 im=-2 per 8 beats, dout_last on 4th, 2-cycle latency.
//  2. Slot k fed re=k, im=0 for ACC_LEN=8 frames -> dout re=8k im=0, k=0..3 in order.
//  3. din_valid toggled 50% random, same data as 1 -> identical results and order, no overflow.
//  4. dout_ready=0 for 40 beats, FIFO_DEPTH=16, N_BASELINES=4, ACC_LEN=1 -> 16 stored, then overflow=1; on release first 16 results drain intact.
//  5. ACC_W=10, re=255 x8 frames: without macro -> wrapped 2040 mod 1024 = 1016 (-8 as signed); with XENG_ACC_SATURATE_EN -> 511, overflow=1.
//  6. rst asserted mid frame 1 slot 2 -> no dout; next beat treated as slot 0 frame 0; overflow=0.

Source files
------------

// File: rtl/xeng_pkg.sv
// Shared definitions for the X-engine accumulator path: default widths, {re,im} packing
// order, and the complex-component unpack/sign-extend helpers.
package xeng_pkg;

    localparam int unsigned IN_W_DEF  = 9;
    localparam int unsigned ACC_W_DEF = 24;
    // Packed complex words carry the real part in the upper half: {re, im}.
    localparam bit          RE_IS_MSB = 1'b1;

    function automatic logic [63:0] sext(input logic [63:0] x, input int unsigned w);
        logic signed [63:0] t;
        t = signed'(x << (64 - w));
        return 64'(t >>> (64 - w));
    endfunction

    // Pull one w-bit component out of a packed complex word and sign-extend it to 64 bits.
    function automatic logic [63:0] cplx_ext(input logic [63:0] word, input int unsigned w,
                                             input logic re_sel);
        logic [63:0] part;
        part = word;
        if (re_sel == RE_IS_MSB) begin
            part = word >> w;
        end
        return sext(part, w);
    endfunction

endpackage

// File: rtl/xeng_acc_fifo.sv
// Synchronous result FIFO with a registered head; total storage (memory + head) is DEPTH entries.
module xeng_acc_fifo #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready_c,
    output logic              full_c,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [DATA_W:0]  mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] mem_count;
    logic [CNT_W-1:0] used_c;
    logic             pop_c;
    logic             push_c;
    logic             load_c;

    // Occupancy counts the head register so the FIFO holds exactly DEPTH results.
    always_comb begin
        used_c     = mem_count + CNT_W'(rd_valid);
        full_c     = (used_c == CNT_W'(DEPTH));
        pop_c      = rd_valid & rd_ready;
        wr_ready_c = !full_c || pop_c;
        push_c     = wr_en & wr_ready_c;
        load_c     = (mem_count != '0) && (!rd_valid || rd_ready);
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= {wr_last, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load_c) begin
                rd_ptr              <= rd_ptr + AW'(1);
                {rd_last, rd_data}  <= mem[rd_ptr];
                rd_valid            <= 1'b1;
            end else if (pop_c) begin
                rd_valid <= 1'b0;
            end
            mem_count <= mem_count + CNT_W'(push_c) - CNT_W'(load_c);
        end
    end

endmodule

// File: rtl/xeng_cmac_acc_readout.sv
// Per-baseline complex integrator for the MAC-chain output stream with a valid/ready drain FIFO.
// Define XENG_ACC_SATURATE_EN for saturating accumulation (otherwise modular wrap).
module xeng_cmac_acc_readout
    import xeng_pkg::*;
#(
    parameter int unsigned N_BASELINES = 16,
    parameter int unsigned ACC_LEN     = 8,
    parameter int unsigned IN_W        = IN_W_DEF,
    parameter int unsigned ACC_W       = ACC_W_DEF,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*IN_W-1:0]  din,
    input  logic               din_valid,
    output logic [2*ACC_W-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic               overflow
);

    localparam int unsigned SLOT_W  = (N_BASELINES > 1) ? $clog2(N_BASELINES) : 1;
    localparam int unsigned FRAME_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    logic [SLOT_W-1:0]  slot_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic [2*ACC_W-1:0] acc_mem [N_BASELINES];

    logic [ACC_W-1:0]   ext_re_c, ext_im_c;
    logic [ACC_W-1:0]   sum_re_c, sum_im_c;
    logic [ACC_W:0]     add_re_c, add_im_c;
    logic               first_frame_c, last_frame_c, last_slot_c;
    logic               sat_c, wr_en_c, fifo_wr_ready_c, fifo_full_c;

    // Returns {saturated, sum}; the flag can only be set in the saturating build.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
`ifdef XENG_ACC_SATURATE_EN
        if (s[ACC_W] != s[ACC_W-1]) begin
            return s[ACC_W] ? {1'b1, 1'b1, {(ACC_W-1){1'b0}}}
                            : {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    always_comb begin
        ext_re_c      = ACC_W'(cplx_ext(64'(din), IN_W, 1'b1));
        ext_im_c      = ACC_W'(cplx_ext(64'(din), IN_W, 1'b0));
        first_frame_c = (frame_cnt == '0);
        last_frame_c  = (frame_cnt == FRAME_W'(ACC_LEN - 1));
        last_slot_c   = (slot_cnt == SLOT_W'(N_BASELINES - 1));
        add_re_c      = acc_add(acc_mem[slot_cnt][2*ACC_W-1:ACC_W], ext_re_c);
        add_im_c      = acc_add(acc_mem[slot_cnt][ACC_W-1:0], ext_im_c);
        sum_re_c      = first_frame_c ? ext_re_c : add_re_c[ACC_W-1:0];
        sum_im_c      = first_frame_c ? ext_im_c : add_im_c[ACC_W-1:0];
        sat_c         = !first_frame_c && (add_re_c[ACC_W] || add_im_c[ACC_W]);
        wr_en_c       = din_valid && last_frame_c;
    end

    // Accumulator RAM: single write port, contents need no reset.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            acc_mem[slot_cnt] <= {sum_re_c, sum_im_c};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt  <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else if (din_valid) begin
            if (last_slot_c) begin
                slot_cnt  <= '0;
                frame_cnt <= last_frame_c ? '0 : frame_cnt + FRAME_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
            if ((wr_en_c && fifo_full_c && !(dout_valid && dout_ready)) || sat_c) begin
                overflow <= 1'b1;
            end
        end
    end

    xeng_acc_fifo #(
        .DATA_W (2*ACC_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en_c),
        .wr_data    ({sum_re_c, sum_im_c}),
        .wr_last    (last_slot_c),
        .wr_ready_c (fifo_wr_ready_c),
        .full_c     (fifo_full_c),
        .rd_ready   (dout_ready),
        .rd_valid   (dout_valid),
        .rd_data    (dout),
        .rd_last    (dout_last)
    );

    // A write the FIFO cannot take must coincide with the flag used for overflow.
    always_comb begin
        assert (rst || !wr_en_c || fifo_wr_ready_c || fifo_full_c);
    end

endmodule
